// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction memory req/ack port, decoder valid/ready
// port, and the redirect inputs coming back from the controller/datapath.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        PCSrc;
  logic [31:0] branch_target;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, PCSrc, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready, PCSrc, branch_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over req/ack, hands words to the
// decoder over valid/ready, and follows PCSrc redirects.
//   state | meaning
//   IDLE  | out of reset, no request yet
//   REQ   | request to pc outstanding
//   HOLD  | fetched word held for the decoder
//   DROP  | stale request completing, its data will be discarded
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  instr_fetch_if.master  bus
);

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] target;

  assign target = {bus.branch_target[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_INIT;
      addr_q     <= PC_INIT;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (bus.PCSrc) begin
          pc_d    = target;
          state_d = bus.imem_ack ? S_REQ : S_DROP;
        end else if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.PCSrc) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = S_REQ;
        end else if (bus.instr_ready) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.PCSrc) begin
          pc_d = target;
        end else if (bus.imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The issued address only moves when a fresh request starts, so DROP keeps
  // presenting the old address while pc already tracks the redirect target.
  always_comb begin
    addr_d = addr_q;
    if (state_d == S_REQ) addr_d = pc_d;
  end

  assign bus.imem_req    = (state_q == S_REQ) || (state_q == S_DROP);
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, wrap-around
// and async-reset sequences, then randomized traffic against a transaction model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  instr_fetch_if bus0();
  instr_fetch_if bus1();

  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

  assign bus0.imem_rdata    = mem_word(bus0.imem_addr);
  assign bus1.imem_rdata    = mem_word(bus1.imem_addr);
  assign bus1.imem_ack      = 1'b1;
  assign bus1.instr_ready   = 1'b1;
  assign bus1.PCSrc         = 1'b0;
  assign bus1.branch_target = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Transaction-level reference: one outstanding request (possibly stale), at
  // most one held word, and a next-fetch address.
  bit          m_started, m_out, m_drop, m_have;
  logic [31:0] m_out_addr, m_pc, m_instr, m_ipc;

  task automatic model_reset();
    m_started = 0; m_out = 0; m_drop = 0; m_have = 0;
    m_out_addr = 32'h100; m_pc = 32'h100; m_instr = 0; m_ipc = 0;
  endtask

  task automatic issue(input logic [31:0] a);
    m_out = 1; m_out_addr = a; m_drop = 0;
  endtask

  task automatic model_step(input bit ack, input bit ready, input bit pcsrc, input logic [31:0] tgt);
    if (!m_started) begin
      m_started = 1;
      issue(m_pc);
    end else if (pcsrc) begin
      m_pc = {tgt[31:2], 2'b00};
      if (m_have) begin
        m_have = 0;
        issue(m_pc);
      end else if (!m_drop && ack) issue(m_pc);
      else m_drop = 1;
    end else if (m_have) begin
      if (ready) begin
        m_have = 0;
        issue(m_pc);
      end
    end else if (ack) begin
      if (m_drop) issue(m_pc);
      else begin
        m_have = 1; m_instr = mem_word(m_out_addr); m_ipc = m_out_addr;
        m_pc = m_out_addr + 32'd4; m_out = 0;
      end
    end
  endtask

  typedef struct {
    logic        ack, ready, pcsrc;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl[23];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h100, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    for (int i = 7; i <= 11; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 32'h104};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h104};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 32'h203, 1'b0, 32'h0,   1'b1, 32'h108};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 32'h40,  1'b1, 32'h204, 1'b0, 32'h0};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 32'h80,  1'b1, 32'h204, 1'b0, 32'h0};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80};

    rst_n = 1'b0;
    bus0.imem_ack = 0; bus0.instr_ready = 0; bus0.PCSrc = 0; bus0.branch_target = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", bus0.imem_req, 1'b0);
    chk("rst_addr", bus0.imem_addr, 32'h100);
    chk("rst_valid", bus0.instr_valid, 1'b0);
    chk("rst_instr", bus0.instr, 32'h0);
    chk("rst_pc", bus0.instr_pc, 32'h0);
    chk("rst_wrap_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d_req", k), bus0.imem_req, tbl[k].req);
      if (tbl[k].req) chk($sformatf("v%0d_addr", k), bus0.imem_addr, tbl[k].addr);
      chk($sformatf("v%0d_valid", k), bus0.instr_valid, tbl[k].valid);
      if (tbl[k].valid) begin
        chk($sformatf("v%0d_ipc", k), bus0.instr_pc, tbl[k].ipc);
        chk($sformatf("v%0d_instr", k), bus0.instr, mem_word(tbl[k].ipc));
      end
      if (k == 1) chk("wrap_addr0", bus1.imem_addr, 32'hFFFF_FFFC);
      if (k == 2) begin
        chk("wrap_ipc0", bus1.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr0", bus1.instr, mem_word(32'hFFFF_FFFC));
      end
      if (k == 3) begin
        chk("wrap_req1", bus1.imem_req, 1'b1);
        chk("wrap_addr1", bus1.imem_addr, 32'h0);
      end
      if (k == 4) chk("wrap_ipc1", bus1.instr_pc, 32'h0);
      bus0.imem_ack = tbl[k].ack;
      bus0.instr_ready = tbl[k].ready;
      bus0.PCSrc = tbl[k].pcsrc;
      bus0.branch_target = tbl[k].tgt;
    end

    // Still holding 0x80: reset must clear outputs before any clock edge.
    @(negedge clk);
    chk("hold_valid", bus0.instr_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus0.instr_valid, 1'b0);
    chk("arst_req", bus0.imem_req, 1'b0);
    chk("arst_instr", bus0.instr, 32'h0);
    chk("arst_addr", bus0.imem_addr, 32'h100);
    chk("arst_wrap_valid", bus1.instr_valid, 1'b0);
    chk("arst_wrap_req", bus1.imem_req, 1'b0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          a, r, p;
      logic [31:0] t;
      @(negedge clk);
      chk("rnd_req", bus0.imem_req, m_out);
      if (m_out) chk("rnd_addr", bus0.imem_addr, m_out_addr);
      chk("rnd_valid", bus0.instr_valid, m_have);
      if (m_have) begin
        chk("rnd_ipc", bus0.instr_pc, m_ipc);
        chk("rnd_instr", bus0.instr, m_instr);
      end
      a = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 6);
      p = ($urandom_range(0, 9) == 0);
      t = $urandom;
      bus0.imem_ack = a; bus0.instr_ready = r; bus0.PCSrc = p; bus0.branch_target = t;
      @(posedge clk);
      model_step(a, r, p, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
